// File: rtl/sector_requester.sv
// Sector requester: initiator side of the sector-transfer link to the image
// store. Owns a 512x8 sector buffer shared between the core (host port) and
// the responder (sd_buff_* port), issues one-hot read/write requests for a
// sector number, and reports completion or a timeout back to the core.
//
// Handshake: a request (sd_rd[0] or sd_wr[0]) is held with sd_lba stable
// until the responder raises sd_ack; the request drops on that same edge.
// The responder owns the buffer for as long as sd_ack stays high, and the
// transfer ends on the first cycle sd_ack is seen low. The responder only
// samples the request while idle, so dropping it at ack rise is safe.
module sector_requester #(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int LBA_W          = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [LBA_W-1:0] cmd_lba_i,
    input  logic             cmd_rd_i,
    input  logic             cmd_wr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    input  logic [8:0]       host_addr_i,
    input  logic [7:0]       host_din_i,
    input  logic             host_we_i,
    output logic [7:0]       host_dout_o,
    output logic [LBA_W-1:0] sd_lba,
    output logic [1:0]       sd_rd,
    output logic [1:0]       sd_wr,
    input  logic             sd_ack,
    input  logic [8:0]       sd_buff_addr,
    input  logic [7:0]       sd_buff_dout,
    input  logic             sd_buff_wr,
    output logic [7:0]       sd_buff_din
);

    // Counter is wide enough to hold TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ_RD = 3'd1,
        S_REQ_WR = 3'd2,
        S_XFER   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic             xfer_rd;   // current transfer fills the buffer
    logic             rd_req;
    logic             wr_req;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    logic [7:0]       mem [0:511];
    logic             buf_sd_we;
    logic             buf_host_we;

    // Only bit0 of each request vector is meaningful.
    assign sd_rd   = {1'b0, rd_req};
    assign sd_wr   = {1'b0, wr_req};
    assign tmo_hit = (tmo_cnt == CNT_LAST);

    // Transfer FSM with registered request/status outputs and timeout counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= S_IDLE;
            xfer_rd <= 1'b0;
            rd_req  <= 1'b0;
            wr_req  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
            sd_lba  <= '0;
            tmo_cnt <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Read wins over a simultaneous write.
                    if (cmd_rd_i) begin
                        sd_lba  <= cmd_lba_i;
                        rd_req  <= 1'b1;
                        busy_o  <= 1'b1;
                        error_o <= 1'b0;
                        xfer_rd <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_REQ_RD;
                    end else if (cmd_wr_i) begin
                        sd_lba  <= cmd_lba_i;
                        wr_req  <= 1'b1;
                        busy_o  <= 1'b1;
                        error_o <= 1'b0;
                        xfer_rd <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_REQ_WR;
                    end
                end
                S_REQ_RD, S_REQ_WR: begin
                    if (tmo_hit) begin
                        rd_req  <= 1'b0;
                        wr_req  <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        error_o <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        if (sd_ack) begin
                            rd_req <= 1'b0;
                            wr_req <= 1'b0;
                            state  <= S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    if (tmo_hit) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        error_o <= 1'b1;
                        state   <= S_IDLE;
                    end else if (!sd_ack) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Commands are not sampled while done_o is high.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The responder may write only during a read transfer; the host only
    // while no transfer is in progress, so the two never collide.
    assign buf_sd_we   = (state == S_XFER) && xfer_rd && sd_buff_wr;
    assign buf_host_we = host_we_i && !busy_o;

    // Single write port into the sector buffer.
    always_ff @(posedge clk_i) begin
        if (buf_sd_we) begin
            mem[sd_buff_addr] <= sd_buff_dout;
        end else if (buf_host_we) begin
            mem[host_addr_i] <= host_din_i;
        end
    end

    // Responder read is asynchronous: it samples data the clock after it
    // moves the address, so the data must follow the address immediately.
    assign sd_buff_din = mem[sd_buff_addr];

    // Registered host read; a same-cycle host write returns the old byte.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            host_dout_o <= 8'h00;
        end else begin
            host_dout_o <= mem[host_addr_i];
        end
    end

endmodule

// File: doc/sector_requester.md
Name: sector_requester

Overview:
- Initiator side of the sector-transfer interface between the disk/FDC logic and the image store.
- Owns a 512x8 sector buffer and presents a byte port to the core.
- On command, drives `sd_lba` and a one-hot read or write request, then waits for the image-store responder to move the sector through `sd_buff_*`.
- Reports completion, or a timeout error, back to the core.

Parameters:
- `TIMEOUT_CYCLES`, 1048576, clocks allowed from request assertion to `sd_ack` falling before aborting with error.
- `LBA_W`, 32, width of `sd_lba`.

Ports:
- `clk_i`  in  1  system clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `cmd_lba_i`  in  LBA_W  sector number for the next command
- `cmd_rd_i`  in  1  one-cycle pulse: fetch sector into the buffer
- `cmd_wr_i`  in  1  one-cycle pulse: flush the buffer to the sector
- `busy_o`  out  1  transfer in progress
- `done_o`  out  1  one-cycle pulse at the end of a transfer
- `error_o`  out  1  sticky timeout flag; cleared by the next accepted command
- `host_addr_i`  in  9  core-side buffer byte address
- `host_din_i`  in  8  core-side write data
- `host_we_i`  in  1  core-side write strobe
- `host_dout_o`  out  8  core-side read data, registered, 1-cycle latency
- `sd_lba`  out  LBA_W  sector address to the responder
- `sd_rd`  out  2  read request; bit0 used, bit1 tied 0
- `sd_wr`  out  2  write request; bit0 used, bit1 tied 0
- `sd_ack`  in  1  responder owns the buffer while high
- `sd_buff_addr`  in  9  responder buffer address
- `sd_buff_dout`  in  8  responder data into the buffer
- `sd_buff_wr`  in  1  responder write strobe into the buffer
- `sd_buff_din`  out  8  buffer data to the responder

Behaviour:
- **Reset** (async assert, sync release): state IDLE.
  - `sd_rd`, `sd_wr`, `busy_o`, `done_o`, `error_o` = 0.
  - `sd_lba` = 0; `host_dout_o` = 0.
  - Buffer contents are undefined after reset.
- **IDLE**:
  - `cmd_rd_i` → latch `cmd_lba_i` into `sd_lba`, `sd_rd[0]`=1, `busy_o`=1, `error_o`=0, go REQ_RD.
  - `cmd_wr_i` → same with `sd_wr[0]`=1, go REQ_WR.
  - Both pulses in the same cycle: read wins, write is dropped.
  - `sd_rd`/`sd_wr` assert on the clock edge after the command pulse.
- **REQ_RD / REQ_WR**:
  - Hold the request and `sd_lba` stable.
  - On `sd_ack`=1, drop the request on the same edge and go XFER.
  - The responder samples the request only while idle, so dropping it at ack rise is safe.
- **XFER**:
  - For a read: every cycle with `sd_buff_wr`=1, write `buffer[sd_buff_addr]` <= `sd_buff_dout`.
  - `sd_buff_din` = `buffer[sd_buff_addr]` combinationally (asynchronous read), valid in the same cycle the address changes. The responder samples data on the clock after it updates the address, so registered read is not allowed.
  - On `sd_ack`=0, go DONE.
- **DONE**: `done_o`=1 for one cycle, `busy_o`=0, go IDLE. The next command is accepted in the cycle after `done_o`.
- **Timeout**:
  - A counter starts at request assertion and runs through REQ and XFER.
  - When it reaches `TIMEOUT_CYCLES`-1: clear `sd_rd`/`sd_wr`, set `error_o`=1, pulse `done_o`, return to IDLE.
  - Buffer contents are then unspecified.
- **Host port**:
  - `host_dout_o` <= `buffer[host_addr_i]` every cycle.
  - `host_we_i` writes the buffer only while `busy_o`=0; ignored while busy.
  - A host write and a host read to the same address in the same cycle: `host_dout_o` returns old data (read-before-write).
- **Commands while busy** are ignored. No queueing and no error.
- **`sd_buff_wr` outside XFER** is ignored; the buffer is protected.
- **Address arithmetic**: 9-bit, no wrap logic needed; the responder covers 0..511 exactly once per sector.
- **Reset mid-transfer**: the request drops immediately (async). A responder still holding `sd_ack` is ignored until IDLE-state logic sees a new command. A new command issued while `sd_ack` is still high from the aborted transfer is accepted: go REQ, and XFER is entered immediately since ack is already high.

Test Plan:
1. Read path: `cmd_lba_i`=0x0000_0005, `cmd_rd_i` pulse → `sd_rd`=2'b01 and `sd_lba`=5 next cycle. Responder model writes byte i = i^0xA5 for i=0..511 → one `done_o` pulse after ack falls; host reads of addr 0, 255, 511 return 0xA5, 0x5A, 0x5A.
2. Write path: host writes 0x00..0xFF twice into 0..511, then `cmd_wr_i` with lba 0x7FF. Responder model samples `sd_buff_din` one cycle after each address change → captures 512 bytes equal to addr[7:0]; `sd_wr` clears at ack rise.
3. Timeout with `TIMEOUT_CYCLES`=64 and no ack → at cycle 64 after request, `sd_rd`=0, `error_o`=1, one `done_o` pulse. The next `cmd_rd_i` clears `error_o`.
4. Simultaneous `cmd_rd_i`+`cmd_wr_i` → only `sd_rd[0]` asserts. A second `cmd_wr_i` while busy → no effect; exactly one `done_o`.
5. Host write during XFER to addr 10 (value 0xEE) while responder writes 0x11 there → buffer holds 0x11 after done.
6. `reset_n_i` low mid-XFER (byte 200) → all outputs at reset values within the same cycle. After release, a new read completes normally with correct data.
